// File: rtl/countdown_timer.sv
// Calendar-style countdown timer: loads Y/M/D h:m:s and counts down one second per tick.
// Optional COUNTDOWN_AUTO_RELOAD_EN reloads the last loaded duration on reaching zero.
module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [5:0] second_in,
  input  logic [5:0] minute_in,
  input  logic [4:0] hour_in,
  input  logic [4:0] day_in,
  input  logic [3:0] month_in,
  input  logic [6:0] year_in,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       running,
  output logic       done,
  output logic       expired
);

  // state    | meaning
  // ST_IDLE  | loaded or reset, waiting for start
  // ST_RUN   | counting down
  // ST_PAUSE | stopped mid-count, count and prescaler held
  // ST_DONE  | count reached zero
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  localparam logic [19:0] PS_LAST = 20'(TICKS_PER_SEC - 1);

  state_t      state, state_nxt;
  logic [19:0] prescale, prescale_nxt;
  logic [32:0] cnt, cnt_nxt;
  logic [32:0] ld_cnt, dec_cnt;
  logic        done_nxt;
  logic        cnt_zero, dec_zero;

  logic [5:0] ld_sec, ld_min, dec_sec, dec_min;
  logic [4:0] ld_hr, ld_day, dec_hr, dec_day;
  logic [3:0] ld_mon, dec_mon;
  logic [6:0] ld_yr, dec_yr;
  logic       b_min, b_hr, b_day, b_mon, b_yr;

  // field layout: year | month | day | hour | minute | second
  assign year   = cnt[32:26];
  assign month  = cnt[25:22];
  assign day    = cnt[21:17];
  assign hour   = cnt[16:12];
  assign minute = cnt[11:6];
  assign second = cnt[5:0];

  assign ld_sec = (second_in > 6'd59) ? 6'd59 : second_in;
  assign ld_min = (minute_in > 6'd59) ? 6'd59 : minute_in;
  assign ld_hr  = (hour_in   > 5'd23) ? 5'd23 : hour_in;
  assign ld_day = (day_in    > 5'd29) ? 5'd29 : day_in;
  assign ld_mon = (month_in  > 4'd11) ? 4'd11 : month_in;
  assign ld_yr  = (year_in   > 7'd99) ? 7'd99 : year_in;
  assign ld_cnt = {ld_yr, ld_mon, ld_day, ld_hr, ld_min, ld_sec};

  always_comb begin
    dec_sec = (second == 6'd0) ? 6'd59 : second - 6'd1;
    b_min   = (second == 6'd0);
    dec_min = minute;
    b_hr    = 1'b0;
    if (b_min) begin
      dec_min = (minute == 6'd0) ? 6'd59 : minute - 6'd1;
      b_hr    = (minute == 6'd0);
    end
    dec_hr = hour;
    b_day  = 1'b0;
    if (b_hr) begin
      dec_hr = (hour == 5'd0) ? 5'd23 : hour - 5'd1;
      b_day  = (hour == 5'd0);
    end
    dec_day = day;
    b_mon   = 1'b0;
    if (b_day) begin
      dec_day = (day == 5'd0) ? 5'd29 : day - 5'd1;
      b_mon   = (day == 5'd0);
    end
    dec_mon = month;
    b_yr    = 1'b0;
    if (b_mon) begin
      dec_mon = (month == 4'd0) ? 4'd11 : month - 4'd1;
      b_yr    = (month == 4'd0);
    end
    // year never underflows: an all-zero count leaves RUN before another tick
    dec_yr = b_yr ? year - 7'd1 : year;
  end

  assign dec_cnt  = {dec_yr, dec_mon, dec_day, dec_hr, dec_min, dec_sec};
  assign cnt_zero = (cnt == 33'd0);
  assign dec_zero = (dec_cnt == 33'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [32:0] shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (load && state != ST_RUN) begin
      shadow <= ld_cnt;
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    prescale_nxt = prescale;
    cnt_nxt      = cnt;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          cnt_nxt      = ld_cnt;
          prescale_nxt = '0;
        end else if (stop) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          if (cnt_zero) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt    = ST_RUN;
            prescale_nxt = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (load) begin
          state_nxt    = ST_IDLE;
          cnt_nxt      = ld_cnt;
          prescale_nxt = '0;
        end else if (stop) begin
          state_nxt = ST_PAUSE;
        end else if (start && !cnt_zero) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (load) begin
          state_nxt    = ST_IDLE;
          cnt_nxt      = ld_cnt;
          prescale_nxt = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_PAUSE;
        end else if (prescale == PS_LAST) begin
          prescale_nxt = '0;
          cnt_nxt      = dec_cnt;
          if (dec_zero) begin
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (shadow != 33'd0) begin
              cnt_nxt   = shadow;
              state_nxt = ST_RUN;
            end
`endif
          end
        end else begin
          prescale_nxt = prescale + 20'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      prescale <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prescale <= prescale_nxt;
      cnt      <= cnt_nxt;
      done     <= done_nxt;
      running  <= (state_nxt == ST_RUN);
      expired  <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; one instance at 1 tick/s, one at 4.
// Auto-reload expectations follow COUNTDOWN_AUTO_RELOAD_EN when the bench is built with it.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, load, start, stop;
  logic [5:0] second_in, minute_in;
  logic [4:0] hour_in, day_in;
  logic [3:0] month_in;
  logic [6:0] year_in;

  logic [5:0] sec1, min1, sec4, min4;
  logic [4:0] hr1, day1, hr4, day4;
  logic [3:0] mon1, mon4;
  logic [6:0] yr1, yr4;
  logic       run1, done1, exp1, run4, done4, exp4;
  logic [32:0] cnt1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign cnt1 = {yr1, mon1, day1, hr1, min1, sec1};

  countdown_timer #(.TICKS_PER_SEC(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
    .second_in(second_in), .minute_in(minute_in), .hour_in(hour_in),
    .day_in(day_in), .month_in(month_in), .year_in(year_in),
    .second(sec1), .minute(min1), .hour(hr1), .day(day1), .month(mon1), .year(yr1),
    .running(run1), .done(done1), .expired(exp1)
  );

  countdown_timer #(.TICKS_PER_SEC(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
    .second_in(second_in), .minute_in(minute_in), .hour_in(hour_in),
    .day_in(day_in), .month_in(month_in), .year_in(year_in),
    .second(sec4), .minute(min4), .hour(hr4), .day(day4), .month(mon4), .year(yr4),
    .running(run4), .done(done4), .expired(exp4)
  );

  function automatic logic [32:0] pk(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return {7'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  task automatic chk_cnt(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d/%0d/%0d %0d:%0d:%0d expected %0d/%0d/%0d %0d:%0d:%0d", tag,
             obs[32:26], obs[25:22], obs[21:17], obs[16:12], obs[11:6], obs[5:0],
             exp[32:26], exp[25:22], exp[21:17], exp[16:12], exp[11:6], exp[5:0]);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int y, input int mo, input int d,
                        input int h, input int mi, input int s);
    year_in   = 7'(y);
    month_in  = 4'(mo);
    day_in    = 5'(d);
    hour_in   = 5'(h);
    minute_in = 6'(mi);
    second_in = 6'(s);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    step(2);
    chk_cnt("rst_cnt", cnt1, 33'd0);
    chk_bit("rst_running", run1, 1'b0);
    chk_bit("rst_done", done1, 1'b0);
    chk_bit("rst_expired", exp1, 1'b0);

    // 00:01:05 = 65 s, start sampled at edge N
    reset = 1'b1;
    load = 1'b1; set_in(0, 0, 0, 0, 1, 5);
    step; load = 1'b0;
    chk_cnt("load_65", cnt1, pk(0, 0, 0, 0, 1, 5));
    chk_bit("load_idle", run1, 1'b0);
    start = 1'b1;
    step; start = 1'b0;
    chk_bit("start_running", run1, 1'b1);
    chk_cnt("start_nodec", cnt1, pk(0, 0, 0, 0, 1, 5));
    step(5);
    chk_cnt("n5", cnt1, pk(0, 0, 0, 0, 1, 0));
    step;
    chk_cnt("n6_borrow", cnt1, pk(0, 0, 0, 0, 0, 59));
    step(58);
    chk_cnt("n64", cnt1, pk(0, 0, 0, 0, 0, 1));
    chk_bit("n64_done", done1, 1'b0);
    step;
    chk_cnt("n65_cnt", cnt1, AR ? pk(0, 0, 0, 0, 1, 5) : 33'd0);
    chk_bit("n65_done", done1, 1'b1);
    chk_bit("n65_expired", exp1, !AR);
    chk_bit("n65_running", run1, AR);
    step;
    chk_bit("n66_done", done1, 1'b0);
    chk_bit("n66_expired", exp1, !AR);
    chk_cnt("n66_cnt", cnt1, AR ? pk(0, 0, 0, 0, 1, 4) : 33'd0);
    stop = 1'b1;
    step; stop = 1'b0;

    // full borrow chain from 1/0/0 00:00:00
    load = 1'b1; set_in(1, 0, 0, 0, 0, 0);
    step; load = 1'b0;
    start = 1'b1;
    step; start = 1'b0;
    chk_bit("borrow_running", run1, 1'b1);
    step;
    chk_cnt("borrow_chain", cnt1, pk(0, 11, 29, 23, 59, 59));
    load = 1'b1; set_in(0, 0, 0, 0, 0, 5);
    step; load = 1'b0;
    chk_cnt("load_in_run", cnt1, pk(0, 11, 29, 23, 59, 58));
    chk_bit("load_in_run_running", run1, 1'b1);
    stop = 1'b1;
    step; stop = 1'b0;
    chk_bit("stop_running", run1, 1'b0);
    chk_cnt("stop_hold", cnt1, pk(0, 11, 29, 23, 59, 58));
    step(3);
    chk_cnt("pause_hold", cnt1, pk(0, 11, 29, 23, 59, 58));

    // saturation and start+stop priority in IDLE
    load = 1'b1; set_in(127, 15, 31, 31, 63, 63);
    step; load = 1'b0;
    chk_cnt("saturate", cnt1, pk(99, 11, 29, 23, 59, 59));
    chk_bit("saturate_idle", run1, 1'b0);
    start = 1'b1; stop = 1'b1;
    step; start = 1'b0; stop = 1'b0;
    chk_bit("start_stop_idle", run1, 1'b0);
    step(2);
    chk_cnt("start_stop_hold", cnt1, pk(99, 11, 29, 23, 59, 59));

    // zero-count start goes straight to DONE
    load = 1'b1; set_in(0, 0, 0, 0, 0, 0);
    step; load = 1'b0;
    start = 1'b1;
    step; start = 1'b0;
    chk_bit("zero_done", done1, 1'b1);
    chk_bit("zero_expired", exp1, 1'b1);
    chk_bit("zero_running", run1, 1'b0);
    step;
    chk_bit("zero_done_drop", done1, 1'b0);
    chk_bit("zero_expired_hold", exp1, 1'b1);
    start = 1'b1;
    step; start = 1'b0;
    chk_bit("done_start_ign_run", run1, 1'b0);
    chk_bit("done_start_ign_exp", exp1, 1'b1);
    chk_bit("done_start_ign_done", done1, 1'b0);

    // asynchronous reset mid-count
    load = 1'b1; set_in(0, 0, 0, 0, 1, 5);
    step; load = 1'b0;
    start = 1'b1;
    step; start = 1'b0;
    step(3);
    chk_cnt("pre_reset_cnt", cnt1, pk(0, 0, 0, 0, 1, 2));
    reset = 1'b0;
    #1;
    chk_cnt("async_rst_cnt", cnt1, 33'd0);
    chk_bit("async_rst_running", run1, 1'b0);
    chk_bit("async_rst_done", done1, 1'b0);
    chk_bit("async_rst_expired", exp1, 1'b0);
    #2;
    reset = 1'b1;
    step;

    // pause/resume on the 4-cycle instance; prescaler held at 2 across the pause
    load = 1'b1; set_in(0, 0, 0, 0, 0, 10);
    step; load = 1'b0;
    start = 1'b1;
    step; start = 1'b0;
    chk_bit("p4_running", run4, 1'b1);
    step(3);
    chk_cnt("p4_n3", {1'b0, 26'd0, sec4}, 33'd10);
    step;
    chk_cnt("p4_n4", {1'b0, 26'd0, sec4}, 33'd9);
    step(2);
    chk_cnt("p4_n6", {1'b0, 26'd0, sec4}, 33'd9);
    stop = 1'b1;
    step; stop = 1'b0;
    chk_bit("p4_paused", run4, 1'b0);
    step(10);
    chk_cnt("p4_pause_hold", {1'b0, 26'd0, sec4}, 33'd9);
    start = 1'b1;
    step; start = 1'b0;
    chk_bit("p4_resumed", run4, 1'b1);
    step;
    chk_cnt("p4_m1", {1'b0, 26'd0, sec4}, 33'd9);
    step;
    chk_cnt("p4_m2", {1'b0, 26'd0, sec4}, 33'd8);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reset = 1'b0;
    step;
    reset = 1'b1;
    load = 1'b1; set_in(0, 0, 0, 0, 0, 3);
    step; load = 1'b0;
    start = 1'b1;
    step; start = 1'b0;
    step(3);
    chk_bit("ar_n3_done", done1, 1'b1);
    chk_cnt("ar_n3_cnt", cnt1, pk(0, 0, 0, 0, 0, 3));
    chk_bit("ar_n3_running", run1, 1'b1);
    chk_bit("ar_n3_expired", exp1, 1'b0);
    step;
    chk_bit("ar_n4_done", done1, 1'b0);
    chk_cnt("ar_n4_cnt", cnt1, pk(0, 0, 0, 0, 0, 2));
    step(2);
    chk_bit("ar_n6_done", done1, 1'b1);
    chk_cnt("ar_n6_cnt", cnt1, pk(0, 0, 0, 0, 0, 3));
    step(3);
    chk_bit("ar_n9_done", done1, 1'b1);
    chk_cnt("ar_n9_cnt", cnt1, pk(0, 0, 0, 0, 0, 3));
    chk_bit("ar_n9_running", run1, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
